// File: rtl/fir_tap_sequencer.sv
// Tap sequencer for a serial FIR MAC: keeps a TAPS-deep sample history and
// streams x[n-k] with the coefficient index and phase strobes for each accepted sample.
// Optional macro FIR_SEQ_STALL_CNT_EN adds the saturating drop_cnt stall counter.
module fir_tap_sequencer #(
    parameter int TAPS = 64,
    parameter int DW   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clk_enable,
    input  logic signed [DW-1:0]      in_sample,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic signed [DW-1:0]      input_mux,
    output logic [$clog2(TAPS)-1:0]   coef_addr,
    output logic                      phase_0,
    output logic                      phase_63,
    output logic                      mac_en
`ifdef FIR_SEQ_STALL_CNT_EN
    ,
    output logic [15:0]               drop_cnt
`endif
);
    localparam int AW = $clog2(TAPS);

    typedef enum logic [1:0] {IDLE, RUN, F0, F1} state_t;

    state_t                state;
    logic [AW-1:0]         wp;
    logic [AW-1:0]         k;
    logic [AW-1:0]         rd_idx;
    logic                  mac_q;
    logic                  last_tap;
    logic                  accept;
    logic signed [DW-1:0]  hist [TAPS];

    assign last_tap  = (state == RUN) && (k == AW'(TAPS - 1));
    assign in_ready  = clk_enable && ((state == IDLE) || last_tap);
    assign accept    = in_valid && in_ready;
    assign coef_addr = k;
    assign mac_en    = mac_q && clk_enable;

    // Newest sample sits at wp-1; the tap presented next cycle is k+1 behind it.
    assign rd_idx = wp - k - AW'(2);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            wp        <= '0;
            k         <= '0;
            input_mux <= '0;
            phase_0   <= 1'b0;
            phase_63  <= 1'b0;
            mac_q     <= 1'b0;
            for (int i = 0; i < TAPS; i++) hist[i] <= '0;
        end else if (clk_enable) begin
            if (accept) begin
                hist[wp] <= in_sample;
                wp       <= wp + AW'(1);
                // x[n] is being written this edge, so bypass it straight to the operand.
                state     <= RUN;
                k         <= '0;
                input_mux <= in_sample;
                mac_q     <= 1'b1;
                phase_0   <= 1'b1;
                phase_63  <= 1'b0;
            end else begin
                case (state)
                    RUN: begin
                        if (last_tap) begin
                            state     <= F0;
                            k         <= '0;
                            input_mux <= '0;
                            mac_q     <= 1'b0;
                            phase_0   <= 1'b1;
                            phase_63  <= 1'b0;
                        end else begin
                            k         <= k + AW'(1);
                            input_mux <= hist[rd_idx];
                            mac_q     <= 1'b1;
                            phase_0   <= 1'b0;
                            phase_63  <= (k == AW'(TAPS - 2));
                        end
                    end
                    F0: begin
                        state    <= F1;
                        phase_0  <= 1'b0;
                        phase_63 <= 1'b1;
                    end
                    F1: begin
                        state    <= IDLE;
                        phase_63 <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef FIR_SEQ_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            drop_cnt <= '0;
        else if (clk_enable && in_valid && !in_ready && (drop_cnt != 16'hFFFF))
            drop_cnt <= drop_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench for fir_tap_sequencer: impulse, history wrap, back-to-back,
// mid-frame reset, enable freeze and (with FIR_SEQ_STALL_CNT_EN) the stall counter.
module tb_fir_tap_sequencer;
    logic        clk = 1'b0;
    logic        rst_n, clk_enable, in_valid, in_ready;
    logic [15:0] in_sample, input_mux;
    logic [5:0]  coef_addr;
    logic        phase_0, phase_63, mac_en;
`ifdef FIR_SEQ_STALL_CNT_EN
    logic [15:0] drop_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fir_tap_sequencer #(.TAPS(64), .DW(16)) dut (
        .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable),
        .in_sample(in_sample), .in_valid(in_valid), .in_ready(in_ready),
        .input_mux(input_mux), .coef_addr(coef_addr),
        .phase_0(phase_0), .phase_63(phase_63), .mac_en(mac_en)
`ifdef FIR_SEQ_STALL_CNT_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, ".mux"},      32'(input_mux), 32'd0);
        chk({tag, ".coef"},     32'(coef_addr), 32'd0);
        chk({tag, ".ph0"},      32'(phase_0), 32'd0);
        chk({tag, ".ph63"},     32'(phase_63), 32'd0);
        chk({tag, ".mac_en"},   32'(mac_en), 32'd0);
    endtask

    // Steps until in_ready is seen; an expired bound counts as a failure.
    task automatic wait_ready(input string tag);
        int n = 0;
        while (!in_ready && n < 200) begin
            step();
            n++;
        end
        chk({tag, ".ready_timeout"}, 32'(in_ready), 32'd1);
    endtask

    // Finishes a frame parked at k=63 with no accept: F0, F1, IDLE.
    task automatic drain(input string tag);
        step();
        chk({tag, ".f0.ph0"},    32'(phase_0), 32'd1);
        chk({tag, ".f0.mac_en"}, 32'(mac_en), 32'd0);
        chk({tag, ".f0.mux"},    32'(input_mux), 32'd0);
        chk({tag, ".f0.ready"},  32'(in_ready), 32'd0);
        step();
        chk({tag, ".f1.ph63"},   32'(phase_63), 32'd1);
        chk({tag, ".f1.ph0"},    32'(phase_0), 32'd0);
        chk({tag, ".f1.mac_en"}, 32'(mac_en), 32'd0);
        step();
        chk_idle_outputs({tag, ".idle"});
    endtask

    initial begin
        rst_n = 1'b0; clk_enable = 1'b1; in_valid = 1'b0; in_sample = '0;
        step(); step();
        rst_n = 1'b1;
        chk_idle_outputs("reset");
`ifdef FIR_SEQ_STALL_CNT_EN
        chk("reset.drop", 32'(drop_cnt), 32'd0);
`endif

        // Impulse into an all-zero history
        in_valid = 1'b1; in_sample = 16'h4000;
        step();
        in_valid = 1'b0;
        chk("imp.k0.mux", 32'(input_mux), 32'h4000);
        chk("imp.k0.ph0", 32'(phase_0), 32'd1);
        chk("imp.k0.mac", 32'(mac_en), 32'd1);
        chk("imp.k0.coef", 32'(coef_addr), 32'd0);
        chk("imp.k0.ready", 32'(in_ready), 32'd0);
        for (int k = 1; k < 64; k++) begin
            step();
            chk("imp.coef", 32'(coef_addr), 32'(k));
            chk("imp.mux", 32'(input_mux), 32'd0);
            chk("imp.ph63", 32'(phase_63), (k == 63) ? 32'd1 : 32'd0);
            chk("imp.ready", 32'(in_ready), (k == 63) ? 32'd1 : 32'd0);
        end
        drain("imp");

        // 70 back-to-back samples of value i+1, crossing the buffer wrap
        in_valid = 1'b1; in_sample = 16'd1;
        step();
        for (int s = 2; s <= 70; s++) begin
            in_sample = 16'(s);
            repeat (62) step();
            chk("b2b.k62.ready", 32'(in_ready), 32'd0);
            step();
            chk("b2b.k63.ready", 32'(in_ready), 32'd1);
            chk("b2b.k63.ph63", 32'(phase_63), 32'd1);
            step();
            chk("b2b.k0.ph0", 32'(phase_0), 32'd1);
            chk("b2b.k0.mac", 32'(mac_en), 32'd1);
            chk("b2b.k0.mux", 32'(input_mux), 32'(s));
        end
        in_valid = 1'b0;
        for (int k = 0; k < 64; k++) begin
            if (k > 0) step();
            chk("wrap.coef", 32'(coef_addr), 32'(k));
            chk("wrap.mux", 32'(input_mux), 32'(70 - k));
        end
        drain("wrap");
`ifdef FIR_SEQ_STALL_CNT_EN
        chk("wrap.drop", 32'(drop_cnt), 32'd4347);
`endif

        // Reset in the middle of a frame clears outputs and history
        in_valid = 1'b1; in_sample = 16'h1234;
        step();
        in_valid = 1'b0;
        repeat (30) step();
        chk("rst.k30.coef", 32'(coef_addr), 32'd30);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk_idle_outputs("rst");
`ifdef FIR_SEQ_STALL_CNT_EN
        chk("rst.drop", 32'(drop_cnt), 32'd0);
`endif
        in_valid = 1'b1; in_sample = 16'h0777;
        step();
        in_valid = 1'b0;
        chk("rst.imp.k0.mux", 32'(input_mux), 32'h0777);
        for (int k = 1; k < 64; k++) begin
            step();
            chk("rst.imp.mux", 32'(input_mux), 32'd0);
        end
        drain("rst.imp");

        // Eleven samples so frame 11 has x[n-10]=0x200 and x[n-11]=0x777
        in_valid = 1'b1;
        for (int j = 0; j < 11; j++) begin
            in_sample = 16'(16'h0200 + j);
            wait_ready("frz.load");
            step();
        end
        in_valid = 1'b0;
        chk("frz.k0.mux", 32'(input_mux), 32'h020A);
        repeat (10) step();
        chk("frz.k10.coef", 32'(coef_addr), 32'd10);
        chk("frz.k10.mux", 32'(input_mux), 32'h0200);
        clk_enable = 1'b0;
        #1;
        chk("frz.mac_off", 32'(mac_en), 32'd0);
        chk("frz.ready_off", 32'(in_ready), 32'd0);
        repeat (5) step();
        chk("frz.hold.coef", 32'(coef_addr), 32'd10);
        chk("frz.hold.mux", 32'(input_mux), 32'h0200);
        chk("frz.hold.mac", 32'(mac_en), 32'd0);
        clk_enable = 1'b1;
        #1;
        chk("frz.resume.mac", 32'(mac_en), 32'd1);
        chk("frz.resume.coef", 32'(coef_addr), 32'd10);
        step();
        chk("frz.k11.coef", 32'(coef_addr), 32'd11);
        chk("frz.k11.mux", 32'(input_mux), 32'h0777);
        repeat (52) step();
        chk("frz.k63.ph63", 32'(phase_63), 32'd1);
        drain("frz");

`ifdef FIR_SEQ_STALL_CNT_EN
        // Long continuous offer drives the counter into saturation
        in_valid = 1'b1;
        repeat (67000) step();
        chk("sat.drop", 32'(drop_cnt), 32'hFFFF);
        in_valid = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fir_tap_sequencer.md
# fir_tap_sequencer

Front end of the serial 64-tap FIR MAC datapath: accepts one 16-bit audio sample per handshake and keeps a 64-deep history in a circular buffer. Per accepted sample it runs one 64-cycle frame presenting x[n-k] for k = 0..63, with the coefficient address and phase strobes. It drives the MAC/accumulator stage's sample operand (`input_mux`), its phase strobes (`phase_0`, `phase_63`) and its enable (`mac_en`). It also drives the coefficient ROM address.

## Interface
Parameters:
- `TAPS`, 64: frame length / history depth; must be a power of two; address width is log2(TAPS).
- `DW`, 16: sample width, signed.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `clk_enable`  in  1  global enable; when 0, all state frozen and `in_ready`=0.
- `in_sample`  in  DW  signed input sample.
- `in_valid`  in  1  sample offered.
- `in_ready`  out  1  sample accepted when `in_valid & in_ready & clk_enable`.
- `input_mux`  out  DW  signed tap operand x[n-k].
- `coef_addr`  out  log2(TAPS)  coefficient index k.
- `phase_0`  out  1  first tap of frame / commit strobe.
- `phase_63`  out  1  last tap of frame / output strobe.
- `mac_en`  out  1  accumulate enable for the MAC stage.
- `drop_cnt`  out  16  only when `FIR_SEQ_STALL_CNT_EN` is defined.

## Operation
- Sample history: TAPS×DW register array with write pointer `wp`. Reset clears every entry to 0, so startup history is zeros.
- On accept: write `in_sample` at `wp`, then `wp` increments mod TAPS.
- Each tap read for frame n at phase k returns x[n-k]. Read index is (index of x[n] − k) mod TAPS, wrapping below 0.
- State machine (registered): IDLE, RUN, F0, F1.
- IDLE:
  - `in_ready`=1; strobes and `mac_en` = 0.
  - Accept → RUN, k=0.
- RUN:
  - Each cycle: `coef_addr`=k, `input_mux`=x[n-k], `mac_en`=1, `phase_0`=(k==0), `phase_63`=(k==TAPS-1); then k increments.
  - At k=TAPS-1, `in_ready`=1. Accept → RUN with k=0 (back-to-back); otherwise → F0.
- F0: `phase_0`=1, `mac_en`=0, `input_mux`=0. MAC captures the completed sum → F1.
- F1: `phase_63`=1, `mac_en`=0, `input_mux`=0. MAC updates `filtered_sample` → IDLE.
- `in_ready`=0 in RUN (k<TAPS-1), F0 and F1.
- Arithmetic: none on the data. Pointers and k are unsigned, wrap mod TAPS.
- Reset values (every output): `in_ready`=1 (when `clk_enable`=1); `input_mux`=0; `coef_addr`=0; `phase_0`=0; `phase_63`=0; `mac_en`=0; `drop_cnt`=0. State=IDLE, `wp`=0, k=0.
- Reset mid-frame: aborts the frame. Outputs follow the reset values on the next edge and the history is cleared.

## Timing
- Accept at edge T → phase 0 presented during cycle T+1; phase k during T+1+k; phase 63 during T+64.
- Back-to-back accept at T+64 → next `phase_0` at T+65. Throughput: one sample per TAPS cycles; no gap cycles.
- No accept at T+64 → F0 at T+65, F1 at T+66, IDLE (`in_ready`=1) at T+67.
- All outputs except `in_ready` are registered. `in_ready` is a decode of the registered state/k gated by `clk_enable`.
- `clk_enable`=0 in any state: hold state, k, `wp`, buffer and outputs; `mac_en` is forced 0 while low. Resume exactly where paused.

## Configuration
- `FIR_SEQ_STALL_CNT_EN` defined:
  - `drop_cnt` port exists.
  - Counts cycles with `clk_enable`=1, `in_valid`=1 and `in_ready`=0; saturates at 0xFFFF.
  - Cleared by reset.
- Undefined: port and counter are absent; the rest of the behaviour is identical.

## Test plan
- Impulse: reset, accept 0x4000 then idle → RUN shows `input_mux`=0x4000 at k=0 and 0 for k=1..63. `coef_addr` goes 0..63, then F0, F1, IDLE at T+67.
- History wrap: accept 70 samples of value i+1 back-to-back → frame for sample 70 shows `input_mux` = 70−k for k=0..63, crossing the buffer wrap. No F0/F1 between frames; `phase_0` period 64.
- Back-to-back boundary: `in_valid` held high → `in_ready` high only at k=63. Accepts occur every 64 cycles; `phase_63` is immediately followed by `phase_0`.
- Reset mid-frame: `rst_n`=0 at k=30 for one edge → next cycle all outputs 0, `in_ready`=1. The next impulse frame shows zeros for k≥1.
- Enable freeze: `clk_enable`=0 for 5 cycles at k=10 → k, `input_mux` and `coef_addr` held, `mac_en`=0. Resumes at k=10 with `mac_en`=1.
- Stall counter (macro on): `in_valid`=1 continuously for 3 frames → `drop_cnt`=63 per frame (189 total). Forcing 70000 stall cycles → 0xFFFF.
